// File: rtl/card_select.sv
// Cursor and two-card pick controller for a 6x6 memory game board.
// Holds a picked pair for SHOW_CYCLES cycles, then offers it until the game logic accepts.
module card_select #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        btnSel,
    input  logic [35:0] matched,
    input  logic        pairReady,
    output logic [5:0]  selectedCard,
    output logic [5:0]  card1,
    output logic [5:0]  card2,
    output logic        pairValid
);

    localparam int         CNT_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [5:0] NONE  = 6'd63;

    typedef enum logic [1:0] {
        PICK1 = 2'd0,
        PICK2 = 2'd1,
        SHOW  = 2'd2,
        OFFER = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       row;
    logic [2:0]       col;
    logic [2:0]       row_next;
    logic [2:0]       col_next;
    logic [CNT_W-1:0] show_cnt;
    logic             pickable;

    // Opposing pulses on the same axis cancel each other.
    always_comb begin
        row_next = row;
        col_next = col;
        if (btnUp && !btnDown) begin
            row_next = (row == 3'd0) ? 3'd5 : row - 3'd1;
        end else if (btnDown && !btnUp) begin
            row_next = (row == 3'd5) ? 3'd0 : row + 3'd1;
        end
        if (btnLeft && !btnRight) begin
            col_next = (col == 3'd0) ? 3'd5 : col - 3'd1;
        end else if (btnRight && !btnLeft) begin
            col_next = (col == 3'd5) ? 3'd0 : col + 3'd1;
        end
    end

    assign pickable = !matched[selectedCard];

    always_ff @(posedge clock) begin
        if (!resetN) begin
            row          <= 3'd0;
            col          <= 3'd0;
            selectedCard <= 6'd0;
        end else begin
            row          <= row_next;
            col          <= col_next;
            selectedCard <= 6'(row_next) * 6'd6 + 6'(col_next);
        end
    end

    // Picks look at the registered cursor, i.e. the position before any coincident move.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state     <= PICK1;
            card1     <= NONE;
            card2     <= NONE;
            pairValid <= 1'b0;
            show_cnt  <= '0;
        end else begin
            case (state)
                PICK1: begin
                    if (btnSel && pickable) begin
                        card1 <= selectedCard;
                        state <= PICK2;
                    end
                end
                PICK2: begin
                    if (btnSel && pickable && (selectedCard != card1)) begin
                        card2    <= selectedCard;
                        show_cnt <= '0;
                        state    <= SHOW;
                    end
                end
                SHOW: begin
                    show_cnt <= show_cnt + 1'b1;
                    if (show_cnt == CNT_W'(SHOW_CYCLES - 1)) begin
                        state     <= OFFER;
                        pairValid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (pairReady) begin
                        state     <= PICK1;
                        pairValid <= 1'b0;
                        card1     <= NONE;
                        card2     <= NONE;
                    end
                end
                default: begin
                    state     <= PICK1;
                    pairValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
